// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the operand class used by the FP datapath.
package fp32_pkg;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_t;

endpackage

// File: rtl/fp32_classify.sv
// Decodes a binary32 operand into its class and its 24-bit significand.
// Subnormals are flushed to zero.
import fp32_pkg::*;

module fp32_classify (
    input  logic [7:0]  exp,
    input  logic [22:0] frac,
    output fp_class_t   cls,
    output logic [23:0] sig
);

    always_comb begin
        cls = NORMAL;
        sig = {1'b1, frac};
        if (exp == 8'd0) begin
            cls = ZERO;
            sig = 24'd0;
        end else if (exp == 8'(EXP_MAX)) begin
            cls = (frac == 23'd0) ? INF : NAN;
            sig = 24'd0;
        end
    end

endmodule

// File: rtl/fmul.sv
// Single-precision multiplier: classify, multiply, normalise and round
// combinationally, then one output register stage.
import fp32_pkg::*;

module fmul (
    input  logic        clk,
    input  logic        rst,
    input  logic        A_sign,
    input  logic [7:0]  A_exp,
    input  logic [22:0] A_frac,
    input  logic        B_sign,
    input  logic [7:0]  B_exp,
    input  logic [22:0] B_frac,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] frac,
    output logic        error,
    output logic        overflow
);

    fp_class_t          a_cls, b_cls;
    logic [23:0]        a_sig, b_sig;
    logic [47:0]        prod;
    logic signed [9:0]  e_sum, e_norm, e_final;
    logic [22:0]        frac_pre, frac_rnd;
    logic               guard, sticky, round_up, carry, inexact;
    logic               res_sign;

    logic               nxt_sign, nxt_error, nxt_overflow;
    logic [7:0]         nxt_exp;
    logic [23:0]        nxt_frac;

    fp32_classify u_class_a (.exp(A_exp), .frac(A_frac), .cls(a_cls), .sig(a_sig));
    fp32_classify u_class_b (.exp(B_exp), .frac(B_frac), .cls(b_cls), .sig(b_sig));

    assign prod     = 48'(a_sig) * 48'(b_sig);
    assign e_sum    = $signed({2'b00, A_exp}) + $signed({2'b00, B_exp}) - $signed(10'(EXP_BIAS));
    assign res_sign = A_sign ^ B_sign;

    // Product of two 1.f values lies in [1,4): bit 47 picks the normalising shift.
    always_comb begin
        if (prod[47]) begin
            frac_pre = prod[46:24];
            guard    = prod[23];
            sticky   = |prod[22:0];
            e_norm   = e_sum + 10'sd1;
        end else begin
            frac_pre = prod[45:23];
            guard    = prod[22];
            sticky   = |prod[21:0];
            e_norm   = e_sum;
        end
        round_up = guard & (sticky | frac_pre[0]);
        carry    = (&frac_pre) & round_up;
        frac_rnd = frac_pre + 23'(round_up);
        e_final  = e_norm + 10'(carry);
        inexact  = guard | sticky;
    end

    always_comb begin
        nxt_sign     = res_sign;
        nxt_exp      = 8'd0;
        nxt_frac     = 24'd0;
        nxt_error    = 1'b0;
        nxt_overflow = 1'b0;
        if (a_cls == NAN || b_cls == NAN ||
            (a_cls == INF && b_cls == ZERO) || (a_cls == ZERO && b_cls == INF)) begin
            nxt_sign  = QNAN[31];
            nxt_exp   = QNAN[30:23];
            nxt_frac  = {QNAN[22:0], 1'b0};
            nxt_error = 1'b1;
        end else if (a_cls == INF || b_cls == INF) begin
            nxt_exp = 8'(EXP_MAX);
        end else if (a_cls == ZERO || b_cls == ZERO) begin
            nxt_exp = 8'd0;
        end else if (e_final >= $signed(10'(EXP_MAX))) begin
            nxt_exp      = 8'(EXP_MAX);
            nxt_frac     = 24'd1;
            nxt_overflow = 1'b1;
        end else if (e_final <= 10'sd0) begin
            // Results below the normal range are flushed; always lossy.
            nxt_frac = 24'd1;
        end else begin
            nxt_exp  = e_final[7:0];
            nxt_frac = {frac_rnd, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign     <= 1'b0;
            exp      <= 8'd0;
            frac     <= 24'd0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sign     <= nxt_sign;
            exp      <= nxt_exp;
            frac     <= nxt_frac;
            error    <= nxt_error;
            overflow <= nxt_overflow;
        end
    end

endmodule

// File: tb/tb_fmul.sv
// Scoreboard bench for fmul: back-to-back operand stream with expected
// results queued at drive time and compared one cycle later.
module tb_fmul;

    logic        clk = 1'b0;
    logic        rst;
    logic        A_sign, B_sign;
    logic [7:0]  A_exp, B_exp;
    logic [22:0] A_frac, B_frac;
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] frac;
    logic        error;
    logic        overflow;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        inx;
        logic        err;
        logic        ovf;
    } expect_t;

    expect_t     sb[$];
    logic        drv_valid = 1'b0;
    int          checks = 0;
    int          errors = 0;

    fmul dut (
        .clk(clk), .rst(rst),
        .A_sign(A_sign), .A_exp(A_exp), .A_frac(A_frac),
        .B_sign(B_sign), .B_exp(B_exp), .B_frac(B_frac),
        .sign(sign), .exp(exp), .frac(frac),
        .error(error), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] res, input logic inx,
                                 input logic err, input logic ovf);
        expect_t e;
        @(negedge clk);
        {A_sign, A_exp, A_frac} = a;
        {B_sign, B_exp, B_frac} = b;
        drv_valid = 1'b1;
        e.name = name; e.res = res; e.inx = inx; e.err = err; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_res"}, {sign, exp, frac[23:1]}, 32'h0);
        checkOutput({tag, "_inx"}, {31'd0, frac[0]}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, error}, 32'd0);
        checkOutput({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    endtask

    // Monitor: every edge that captured a driven operand pair is scored 1 time unit later.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            if (drv_valid && !rst) begin
                #1;
                if (sb.size() == 0) begin
                    checkOutput("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_res"}, {sign, exp, frac[23:1]}, e.res);
                    checkOutput({e.name, "_inx"}, {31'd0, frac[0]}, {31'd0, e.inx});
                    checkOutput({e.name, "_err"}, {31'd0, error}, {31'd0, e.err});
                    checkOutput({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        {A_sign, A_exp, A_frac} = 32'h3F800000;
        {B_sign, B_exp, B_frac} = 32'h40000000;
        repeat (2) @(posedge clk);
        #1;
        checkZeroOutputs("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("zeros",     32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        applyStimulus("normal",    32'hC3700000, 32'hC2F00000, 32'h46E10000, 1'b0, 1'b0, 1'b0);
        applyStimulus("frac",      32'h40008000, 32'h40808000, 32'h41010080, 1'b0, 1'b0, 1'b0);
        applyStimulus("one_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("two_half",  32'h40000000, 32'h3F000000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("sticky",    32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b1, 1'b0, 1'b0);
        applyStimulus("tie_up",    32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b1, 1'b0, 1'b0);
        applyStimulus("tie_even",  32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b1, 1'b0, 1'b0);
        applyStimulus("inf_inf",   32'h7F800000, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("inf_ninf",  32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("inf_neg1",  32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("inf_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1'b0);
        applyStimulus("nan_a",     32'hFFC00000, 32'hC3700000, 32'h7FC00000, 1'b0, 1'b1, 1'b0);
        applyStimulus("nan_b",     32'h3F800000, 32'h7F800001, 32'h7FC00000, 1'b0, 1'b1, 1'b0);
        applyStimulus("ovf",       32'h62959EB2, 32'h5E31A2BC, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        applyStimulus("ovf_edge",  32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        applyStimulus("max_ok",    32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0, 1'b0);
        applyStimulus("unf",       32'h99208B9C, 32'h21BFD89D, 32'h80000000, 1'b1, 1'b0, 1'b0);
        applyStimulus("min_ok",    32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0, 1'b0);
        applyStimulus("unf_edge",  32'h00800000, 32'h3F000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        applyStimulus("subnorm",   32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0);
        applyStimulus("neg_zero",  32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1'b0);
        applyStimulus("pre_rst",   32'h62959EB2, 32'h5E31A2BC, 32'h7F800000, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of the stream while a live operand pair is on the inputs.
        @(negedge clk);
        drv_valid = 1'b0;
        rst = 1'b1;
        {A_sign, A_exp, A_frac} = 32'hC3700000;
        {B_sign, B_exp, B_frac} = 32'hC2F00000;
        @(posedge clk);
        #1;
        checkZeroOutputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("post_rst",  32'hC3700000, 32'hC2F00000, 32'h46E10000, 1'b0, 1'b0, 1'b0);
        applyStimulus("post_nan",  32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drv_valid = 1'b0;

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        checkOutput("drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
